// File: rtl/audio_mixer_tdm.sv
// audio_mixer_tdm: time-multiplexed NCH-channel stereo mixer with per-channel
// left/right gain, a multiplier pair shared across channels, output saturation
// and per-sample clip flags. One mix pass is triggered by each sample_stb.
//
// Optional build macro: AUDIO_MIXER_TDM_PEAK_EN adds peak-hold meters.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   sample_stb          one-cycle pulse starting a mix pass
//   ch_data             packed signed samples, channel k at [k*IN_W +: IN_W]
//   vol_l, vol_r        packed unsigned gains, 2^(VOL_W-1) = unity
//   mute                zeroes the output sample (sampled at sample_stb)
//   audio_l, audio_r    signed stereo mix, held between valid pulses
//   valid               one-cycle pulse when audio/clip outputs update
//   clip_l, clip_r      saturation flags for the current sample
//   busy                mix pass in progress
//   overrun             sample_stb seen while busy (combinational, same cycle)
//   peak_clr            (PEAK_EN) clear both peak meters
//   peak_l, peak_r      (PEAK_EN) running max of |audio_x|
module audio_mixer_tdm #(
    parameter int unsigned NCH   = 8,
    parameter int unsigned IN_W  = 16,
    parameter int unsigned VOL_W = 8,
    parameter int unsigned OUT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    sample_stb,
    input  logic [NCH*IN_W-1:0]     ch_data,
    input  logic [NCH*VOL_W-1:0]    vol_l,
    input  logic [NCH*VOL_W-1:0]    vol_r,
    input  logic                    mute,
`ifdef AUDIO_MIXER_TDM_PEAK_EN
    input  logic                    peak_clr,
    output logic [OUT_W-2:0]        peak_l,
    output logic [OUT_W-2:0]        peak_r,
`endif
    output logic signed [OUT_W-1:0] audio_l,
    output logic signed [OUT_W-1:0] audio_r,
    output logic                    valid,
    output logic                    clip_l,
    output logic                    clip_r,
    output logic                    busy,
    output logic                    overrun
);

    localparam int unsigned IDX_W  = $clog2(NCH);
    localparam int unsigned PROD_W = IN_W + VOL_W + 1;
    localparam int unsigned ACC_W  = IN_W + VOL_W + $clog2(NCH) + 1;

    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                     state_q, state_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic signed [ACC_W-1:0]    acc_l_q, acc_l_d;
    logic signed [ACC_W-1:0]    acc_r_q, acc_r_d;
    logic [NCH*IN_W-1:0]        ch_q, ch_d;
    logic [NCH*VOL_W-1:0]       vol_l_q, vol_l_d;
    logic [NCH*VOL_W-1:0]       vol_r_q, vol_r_d;
    logic                       mute_q, mute_d;
    logic signed [OUT_W-1:0]    audio_l_q, audio_l_d;
    logic signed [OUT_W-1:0]    audio_r_q, audio_r_d;
    logic                       clip_l_q, clip_l_d;
    logic                       clip_r_q, clip_r_d;
    logic                       valid_q, valid_d;
    logic                       busy_q, busy_d;

    // Shared datapath: current channel times its left/right gain.
    logic signed [IN_W-1:0]     ch_sel;
    logic signed [VOL_W:0]      vl_sel;
    logic signed [VOL_W:0]      vr_sel;
    logic signed [PROD_W-1:0]   prod_l;
    logic signed [PROD_W-1:0]   prod_r;
    logic signed [ACC_W-1:0]    sum_l;
    logic signed [ACC_W-1:0]    sum_r;
    logic [OUT_W:0]             sat_l;
    logic [OUT_W:0]             sat_r;

    // Rescale to unity gain (floor) and clamp; returns {clip, value}.
    function automatic logic [OUT_W:0] saturate(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] sh;
        sh = a >>> (VOL_W - 1);
        if (sh > SAT_MAX) begin
            saturate = {1'b1, SAT_MAX[OUT_W-1:0]};
        end else if (sh < SAT_MIN) begin
            saturate = {1'b1, SAT_MIN[OUT_W-1:0]};
        end else begin
            saturate = {1'b0, sh[OUT_W-1:0]};
        end
    endfunction

    always_comb begin
        ch_sel = ch_q[32'(idx_q)*IN_W +: IN_W];
        vl_sel = {1'b0, vol_l_q[32'(idx_q)*VOL_W +: VOL_W]};
        vr_sel = {1'b0, vol_r_q[32'(idx_q)*VOL_W +: VOL_W]};
        prod_l = PROD_W'(ch_sel) * PROD_W'(vl_sel);
        prod_r = PROD_W'(ch_sel) * PROD_W'(vr_sel);
        sum_l  = acc_l_q + ACC_W'(prod_l);
        sum_r  = acc_r_q + ACC_W'(prod_r);
        sat_l  = saturate(sum_l);
        sat_r  = saturate(sum_r);
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        acc_l_d   = acc_l_q;
        acc_r_d   = acc_r_q;
        ch_d      = ch_q;
        vol_l_d   = vol_l_q;
        vol_r_d   = vol_r_q;
        mute_d    = mute_q;
        audio_l_d = audio_l_q;
        audio_r_d = audio_r_q;
        clip_l_d  = clip_l_q;
        clip_r_d  = clip_r_q;
        valid_d   = 1'b0;
        busy_d    = busy_q;

        case (state_q)
            ST_IDLE: begin
                if (sample_stb) begin
                    ch_d    = ch_data;
                    vol_l_d = vol_l;
                    vol_r_d = vol_r;
                    mute_d  = mute;
                    acc_l_d = '0;
                    acc_r_d = '0;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                acc_l_d = sum_l;
                acc_r_d = sum_r;
                idx_d   = idx_q + IDX_W'(1);
                // Last channel: finish the sum, scale and saturate in the same
                // cycle so the result is registered on entry to DONE.
                if (idx_q == IDX_W'(NCH - 1)) begin
                    idx_d   = '0;
                    valid_d = 1'b1;
                    state_d = ST_DONE;
                    if (mute_q) begin
                        audio_l_d = '0;
                        audio_r_d = '0;
                        clip_l_d  = 1'b0;
                        clip_r_d  = 1'b0;
                    end else begin
                        audio_l_d = sat_l[OUT_W-1:0];
                        audio_r_d = sat_r[OUT_W-1:0];
                        clip_l_d  = sat_l[OUT_W];
                        clip_r_d  = sat_r[OUT_W];
                    end
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            acc_l_q   <= '0;
            acc_r_q   <= '0;
            ch_q      <= '0;
            vol_l_q   <= '0;
            vol_r_q   <= '0;
            mute_q    <= 1'b0;
            audio_l_q <= '0;
            audio_r_q <= '0;
            clip_l_q  <= 1'b0;
            clip_r_q  <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            acc_l_q   <= acc_l_d;
            acc_r_q   <= acc_r_d;
            ch_q      <= ch_d;
            vol_l_q   <= vol_l_d;
            vol_r_q   <= vol_r_d;
            mute_q    <= mute_d;
            audio_l_q <= audio_l_d;
            audio_r_q <= audio_r_d;
            clip_l_q  <= clip_l_d;
            clip_r_q  <= clip_r_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
        end
    end

    assign audio_l = audio_l_q;
    assign audio_r = audio_r_q;
    assign clip_l  = clip_l_q;
    assign clip_r  = clip_r_q;
    assign valid   = valid_q;
    assign busy    = busy_q;
    // Flagged in the same cycle as the rejected strobe.
    assign overrun = sample_stb & busy_q;

`ifdef AUDIO_MIXER_TDM_PEAK_EN
    logic [OUT_W-2:0] peak_l_q, peak_l_d;
    logic [OUT_W-2:0] peak_r_q, peak_r_d;
    logic [OUT_W-2:0] abs_l;
    logic [OUT_W-2:0] abs_r;

    // |x| with the most negative code clamped to the largest positive one.
    function automatic logic [OUT_W-2:0] abs_sat(input logic signed [OUT_W-1:0] x);
        if (!x[OUT_W-1]) begin
            abs_sat = x[OUT_W-2:0];
        end else if (x[OUT_W-2:0] == '0) begin
            abs_sat = '1;
        end else begin
            abs_sat = ~x[OUT_W-2:0] + (OUT_W-1)'(1);
        end
    endfunction

    // Peak hold, updated from the sample presented with valid.
    always_comb begin
        abs_l    = abs_sat(audio_l_q);
        abs_r    = abs_sat(audio_r_q);
        peak_l_d = peak_l_q;
        peak_r_d = peak_r_q;
        if (valid_q) begin
            peak_l_d = (peak_clr || abs_l > peak_l_q) ? abs_l : peak_l_q;
            peak_r_d = (peak_clr || abs_r > peak_r_q) ? abs_r : peak_r_q;
        end else if (peak_clr) begin
            peak_l_d = '0;
            peak_r_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            peak_l_q <= '0;
            peak_r_q <= '0;
        end else begin
            peak_l_q <= peak_l_d;
            peak_r_q <= peak_r_d;
        end
    end

    assign peak_l = peak_l_q;
    assign peak_r = peak_r_q;
`endif

endmodule

// File: tb/tb_audio_mixer_tdm.sv
// Testbench for audio_mixer_tdm (NCH=4, IN_W=16, VOL_W=8, OUT_W=16):
// directed corner cases plus randomized passes against a behavioural model.
module tb_audio_mixer_tdm;

    localparam int NCH   = 4;
    localparam int IN_W  = 16;
    localparam int VOL_W = 8;
    localparam int OUT_W = 16;
    localparam longint UNITY = 128;
    localparam longint OMAX  = 32767;
    localparam longint OMIN  = -32768;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    sample_stb;
    logic [NCH*IN_W-1:0]     ch_data;
    logic [NCH*VOL_W-1:0]    vol_l;
    logic [NCH*VOL_W-1:0]    vol_r;
    logic                    mute;
    logic signed [OUT_W-1:0] audio_l;
    logic signed [OUT_W-1:0] audio_r;
    logic                    valid;
    logic                    clip_l;
    logic                    clip_r;
    logic                    busy;
    logic                    overrun;
`ifdef AUDIO_MIXER_TDM_PEAK_EN
    logic                    peak_clr;
    logic [OUT_W-2:0]        peak_l;
    logic [OUT_W-2:0]        peak_r;
    longint                  pk_l_m;
    longint                  pk_r_m;
`endif

    always #5 clk = ~clk;

    audio_mixer_tdm #(.NCH(NCH), .IN_W(IN_W), .VOL_W(VOL_W), .OUT_W(OUT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sample_stb(sample_stb),
        .ch_data   (ch_data),
        .vol_l     (vol_l),
        .vol_r     (vol_r),
        .mute      (mute),
`ifdef AUDIO_MIXER_TDM_PEAK_EN
        .peak_clr  (peak_clr),
        .peak_l    (peak_l),
        .peak_r    (peak_r),
`endif
        .audio_l   (audio_l),
        .audio_r   (audio_r),
        .valid     (valid),
        .clip_l    (clip_l),
        .clip_r    (clip_r),
        .busy      (busy),
        .overrun   (overrun)
    );

    int checks = 0;
    int errors = 0;

    int ch_m[NCH];
    int vl_m[NCH];
    int vr_m[NCH];
    bit mute_m;

    task automatic check(input string tag, input logic signed [63:0] got,
                         input logic signed [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Model: weighted sum divided by unity gain, floored toward -inf.
    function automatic longint mix(input int chs[NCH], input int vols[NCH]);
        longint s = 0;
        longint q;
        for (int k = 0; k < NCH; k++) s += longint'(chs[k]) * longint'(vols[k]);
        q = s / UNITY;
        if (s < 0 && q * UNITY != s) q -= 1;
        return q;
    endfunction

    function automatic longint clamp(input longint v);
        return (v > OMAX) ? OMAX : ((v < OMIN) ? OMIN : v);
    endfunction

    function automatic longint abs_sat(input longint v);
        longint a = (v < 0) ? -v : v;
        return (a > OMAX) ? OMAX : a;
    endfunction

    task automatic drive_inputs();
        for (int k = 0; k < NCH; k++) begin
            ch_data[k*IN_W +: IN_W]   = IN_W'(ch_m[k]);
            vol_l[k*VOL_W +: VOL_W]   = VOL_W'(vl_m[k]);
            vol_r[k*VOL_W +: VOL_W]   = VOL_W'(vr_m[k]);
        end
        mute = mute_m;
    endtask

    task automatic set_one(input int c0, input int vl0, input int vr0);
        for (int k = 0; k < NCH; k++) begin
            ch_m[k] = 0;
            vl_m[k] = int'($urandom_range(0, 255));
            vr_m[k] = int'($urandom_range(0, 255));
        end
        ch_m[0] = c0;
        vl_m[0] = vl0;
        vr_m[0] = vr0;
        mute_m  = 1'b0;
    endtask

    task automatic set_all(input int c, input int v);
        for (int k = 0; k < NCH; k++) begin
            ch_m[k] = c;
            vl_m[k] = v;
            vr_m[k] = v;
        end
        mute_m = 1'b0;
    endtask

    // mode: 0 plain, 1 strobe+data change at cycle 2, 2 mute toggle mid-pass,
    //       3 strobe in valid cycle, 4 strobe in cycle after valid.
    task automatic run_pass(input int mode, input string tag);
        longint el, er, ql, qr;
        bit     cl, cr;
        int     seen;
        ql = mix(ch_m, vl_m);
        qr = mix(ch_m, vr_m);
        el = clamp(ql);
        er = clamp(qr);
        cl = (el != ql);
        cr = (er != qr);
        if (mute_m) begin
            el = 0; er = 0; cl = 0; cr = 0;
        end

        @(posedge clk); #1;
        drive_inputs();
        sample_stb = 1'b1;
        @(negedge clk);
        check({tag, "/ovr0"}, overrun, 0);
        @(posedge clk); #1;
        sample_stb = 1'b0;
        for (int c = 1; c <= NCH + 2; c++) begin
            if (mode == 1 && c == 2) begin
                ch_data    = {$urandom(), $urandom()};
                sample_stb = 1'b1;
            end
            if (mode == 2 && c == 2) mute = ~mute;
            if (mode == 3 && c == NCH + 1) sample_stb = 1'b1;
            if (mode == 4 && c == NCH + 2) sample_stb = 1'b1;
            @(negedge clk);
            check({tag, "/valid"}, valid, (c == NCH + 1) ? 1 : 0);
            check({tag, "/busy"}, busy, (c <= NCH + 1) ? 1 : 0);
            check({tag, "/ovr"}, overrun,
                  ((mode == 1 && c == 2) || (mode == 3 && c == NCH + 1)) ? 1 : 0);
            if (c >= NCH + 1) begin
                check({tag, "/audio_l"}, audio_l, el);
                check({tag, "/audio_r"}, audio_r, er);
                check({tag, "/clip_l"}, clip_l, cl);
                check({tag, "/clip_r"}, clip_r, cr);
            end
`ifdef AUDIO_MIXER_TDM_PEAK_EN
            if (c == NCH + 1) begin
                if (abs_sat(el) > pk_l_m) pk_l_m = abs_sat(el);
                if (abs_sat(er) > pk_r_m) pk_r_m = abs_sat(er);
            end
            if (c == NCH + 2) begin
                check({tag, "/peak_l"}, peak_l, pk_l_m);
                check({tag, "/peak_r"}, peak_r, pk_r_m);
            end
`endif
            @(posedge clk); #1;
            sample_stb = 1'b0;
        end
        if (mode == 4) begin
            seen = 0;
            for (int c = 1; c <= NCH + 1; c++) begin
                @(negedge clk);
                if (c == 1) check({tag, "/accepted"}, busy, 1);
                if (valid) begin
                    seen++;
                    check({tag, "/re_audio_l"}, audio_l, el);
                    check({tag, "/re_audio_r"}, audio_r, er);
                end
                @(posedge clk); #1;
            end
            check({tag, "/re_valid"}, seen, 1);
`ifdef AUDIO_MIXER_TDM_PEAK_EN
            if (abs_sat(el) > pk_l_m) pk_l_m = abs_sat(el);
            if (abs_sat(er) > pk_r_m) pk_r_m = abs_sat(er);
`endif
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "/audio_l"}, audio_l, 0);
        check({tag, "/audio_r"}, audio_r, 0);
        check({tag, "/valid"}, valid, 0);
        check({tag, "/clip"}, {clip_l, clip_r}, 0);
        check({tag, "/busy"}, busy, 0);
        check({tag, "/overrun"}, overrun, 0);
`ifdef AUDIO_MIXER_TDM_PEAK_EN
        check({tag, "/peak"}, {peak_l, peak_r}, 0);
`endif
    endtask

    initial begin
        int seen;
        rst_n      = 1'b0;
        sample_stb = 1'b0;
        ch_data    = '0;
        vol_l      = '0;
        vol_r      = '0;
        mute       = 1'b0;
`ifdef AUDIO_MIXER_TDM_PEAK_EN
        peak_clr = 1'b0;
        pk_l_m   = 0;
        pk_r_m   = 0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_state("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        set_one(1000, 128, 64);    run_pass(0, "unity");
        set_all(30000, 128);       run_pass(0, "sat_pos");
        set_all(-30000, 128);      run_pass(0, "sat_neg");
        set_one(-3, 64, 64);       run_pass(0, "floor_neg");
        set_one(3, 64, 64);        run_pass(0, "floor_pos");
        set_one(1000, 128, 64);    run_pass(1, "overrun");
        set_one(20000, 255, 255); mute_m = 1'b1; run_pass(0, "mute");
        set_one(20000, 255, 255); mute_m = 1'b1; run_pass(2, "mute_tog1");
        set_one(20000, 255, 255); run_pass(2, "mute_tog0");
        set_one(-32768, 255, 0);   run_pass(3, "stb_valid");
        set_all(12345, 200);       run_pass(4, "stb_after");
        set_all(0, 255);           run_pass(0, "zero");

        // Reset mid-pass: outputs clear at once, no valid follows.
        set_all(5000, 128);
        @(posedge clk); #1;
        drive_inputs();
        sample_stb = 1'b1;
        @(posedge clk); #1;
        sample_stb = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_state("rst_mid");
`ifdef AUDIO_MIXER_TDM_PEAK_EN
        pk_l_m = 0;
        pk_r_m = 0;
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < NCH + 3; c++) begin
            @(negedge clk);
            if (valid || busy) seen++;
        end
        check("rst_mid/no_valid", seen, 0);
        set_one(-1234, 77, 200);   run_pass(0, "post_rst");

`ifdef AUDIO_MIXER_TDM_PEAK_EN
        @(posedge clk); #1;
        peak_clr = 1'b1;
        @(posedge clk); #1;
        peak_clr = 1'b0;
        pk_l_m = 0;
        pk_r_m = 0;
        @(negedge clk);
        check("peak/clr", {peak_l, peak_r}, 0);
        set_one(500, 128, 128);    run_pass(0, "peak500");
        set_one(-700, 128, 128);   run_pass(0, "peak700");
        check("peak/700", peak_l, 700);
        @(posedge clk); #1;
        peak_clr = 1'b1;
        @(posedge clk); #1;
        peak_clr = 1'b0;
        pk_l_m = 0;
        pk_r_m = 0;
        @(negedge clk);
        check("peak/clr2", {peak_l, peak_r}, 0);
`endif

        // Randomized passes, occasionally at full-scale extremes.
        for (int n = 0; n < 40; n++) begin
            for (int k = 0; k < NCH; k++) begin
                case ($urandom_range(0, 5))
                    0:       ch_m[k] = -32768;
                    1:       ch_m[k] = 32767;
                    default: ch_m[k] = int'($urandom_range(0, 65535)) - 32768;
                endcase
                vl_m[k] = int'($urandom_range(0, 255));
                vr_m[k] = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 255));
            end
            mute_m = ($urandom_range(0, 7) == 0);
            run_pass(int'($urandom_range(0, 4)), $sformatf("rand%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
